quarter_sec_stopwatch: RTL and testbench

//  Consumes the 4 Hz square wave from the clock-divider stage (oSIG_4Hz, same

---
 rtl/quarter_sec_stopwatch.sv | 185 ++++++++++++++++++
 tb/tb_quarter_sec_stopwatch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quarter_sec_stopwatch.sv
// -----------------------------------------------------------------------------
// quarter_sec_stopwatch
//
// Purpose:
//   Start/stop/clear stopwatch paced by a slow square wave (nominally 4 Hz)
//   that comes from the clock-divider stage in the same iCLK domain. Each
//   rising edge of that wave is one sub-second tick. Ticks carry into BCD
//   seconds (00-59) and then into a single minutes digit (0..MAX_MIN). The
//   outputs feed the display/LED stage.
//
// Parameters:
//   TICKS_PER_SEC  ticks per second, legal range 2..16
//   MAX_MIN        last minute value before the count wraps, legal range 1..9
//
// Ports:
//   iCLK         in   1  system clock
//   iRST         in   1  synchronous reset, active-high
//   iSIG_4Hz     in   1  slow square wave, synchronous to iCLK
//   iSTART_STOP  in   1  1-cycle pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   iCLEAR       in   1  1-cycle pulse: back to IDLE with all counters zeroed
//   oSUBSEC      out  4  tick count within the second, 0..TICKS_PER_SEC-1
//   oSEC_ONES    out  4  BCD seconds units, 0..9
//   oSEC_TENS    out  4  BCD seconds tens, 0..5
//   oMIN         out  4  minutes, 0..MAX_MIN
//   oRUNNING     out  1  high while the state register holds RUN
//   oTICK        out  1  1-cycle pulse for every counted tick
//   oWRAP        out  1  1-cycle pulse when MAX_MIN:59.last rolls to 0:00.0
//   oSTATE       out  2  current state encoding (0 IDLE, 1 RUN, 2 PAUSE),
//                        for observation only
//
// Control handshake: iSTART_STOP and iCLEAR are single-cycle strobes sampled
// on every rising iCLK edge; there is no back-pressure. Priority is
// iRST > iCLEAR > (tick, iSTART_STOP). A tick is counted only when the
// registered state is RUN on the edge where the tick is seen, so a
// START_STOP strobe on the same cycle as a tick still lets that tick count
// in RUN, and does not let it count in IDLE or PAUSE.
// -----------------------------------------------------------------------------
module quarter_sec_stopwatch #(
    parameter int TICKS_PER_SEC = 4,
    parameter int MAX_MIN       = 9
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSIG_4Hz,
    input  logic       iSTART_STOP,
    input  logic       iCLEAR,
    output logic [3:0] oSUBSEC,
    output logic [3:0] oSEC_ONES,
    output logic [3:0] oSEC_TENS,
    output logic [3:0] oMIN,
    output logic       oRUNNING,
    output logic       oTICK,
    output logic       oWRAP,
    output logic [1:0] oSTATE
);

    // Last legal value of each digit, sized to the digit registers.
    localparam logic [3:0] SUB_LAST  = 4'(TICKS_PER_SEC - 1);
    localparam logic [3:0] ONES_LAST = 4'd9;
    localparam logic [3:0] TENS_LAST = 4'd5;
    localparam logic [3:0] MIN_LAST  = 4'(MAX_MIN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e     state_q,  state_d;
    logic       sig_q;
    logic [3:0] subsec_q, subsec_d;
    logic [3:0] ones_q,   ones_d;
    logic [3:0] tens_q,   tens_d;
    logic [3:0] min_q,    min_d;
    logic       tick_q,   tick_d;
    logic       wrap_q,   wrap_d;

    logic       tick;
    logic       count_en;
    logic       sub_last;
    logic       ones_last;
    logic       tens_last;
    logic       min_last;

    // Rising-edge detect. sig_q resets high so a wave that is already high
    // when reset releases is not mistaken for an edge.
    assign tick = iSIG_4Hz & ~sig_q;

    // A clear on the same cycle wins over counting.
    assign count_en = (state_q == ST_RUN) & tick & ~iCLEAR;

    assign sub_last  = (subsec_q == SUB_LAST);
    assign ones_last = (ones_q   == ONES_LAST);
    assign tens_last = (tens_q   == TENS_LAST);
    assign min_last  = (min_q    == MIN_LAST);

    // Next-state for the run/pause/idle control.
    always_comb begin
        state_d = state_q;
        if (iCLEAR) begin
            state_d = ST_IDLE;
        end else if (iSTART_STOP) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Carry chain. Each digit only moves when every lower digit is at its
    // last value, so digits stay inside their ranges at every step.
    always_comb begin
        subsec_d = subsec_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        min_d    = min_q;
        if (iCLEAR) begin
            subsec_d = 4'd0;
            ones_d   = 4'd0;
            tens_d   = 4'd0;
            min_d    = 4'd0;
        end else if (count_en) begin
            if (!sub_last) begin
                subsec_d = subsec_q + 4'd1;
            end else begin
                subsec_d = 4'd0;
                if (!ones_last) begin
                    ones_d = ones_q + 4'd1;
                end else begin
                    ones_d = 4'd0;
                    if (!tens_last) begin
                        tens_d = tens_q + 4'd1;
                    end else begin
                        tens_d = 4'd0;
                        if (!min_last) begin
                            min_d = min_q + 4'd1;
                        end else begin
                            min_d = 4'd0;
                        end
                    end
                end
            end
        end
    end

    // Pulses are registered alongside the counters so they line up with
    // the new count value. Consecutive ticks are impossible because a
    // rising edge needs at least one low sample in between.
    assign tick_d = count_en;
    assign wrap_d = count_en & sub_last & ones_last & tens_last & min_last;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            sig_q    <= 1'b1;
            subsec_q <= 4'd0;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            min_q    <= 4'd0;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= iSIG_4Hz;
            subsec_q <= subsec_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            min_q    <= min_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    assign oSUBSEC   = subsec_q;
    assign oSEC_ONES = ones_q;
    assign oSEC_TENS = tens_q;
    assign oMIN      = min_q;
    assign oRUNNING  = (state_q == ST_RUN);
    assign oTICK     = tick_q;
    assign oWRAP     = wrap_q;
    assign oSTATE    = state_q;

endmodule

// File: tb/tb_quarter_sec_stopwatch.sv
// -----------------------------------------------------------------------------
// tb_quarter_sec_stopwatch
//
// Self-checking bench for quarter_sec_stopwatch with default parameters
// (4 ticks per second, minutes 0..9). A per-cycle vector table covers reset
// release, start/pause/resume, coincident strobes and clear; hand-written
// sequences with an 8-cycle square wave cover the long carry/wrap cases.
// -----------------------------------------------------------------------------
module tb_quarter_sec_stopwatch;

    logic       iCLK;
    logic       iRST;
    logic       iSIG_4Hz;
    logic       iSTART_STOP;
    logic       iCLEAR;
    logic [3:0] oSUBSEC;
    logic [3:0] oSEC_ONES;
    logic [3:0] oSEC_TENS;
    logic [3:0] oMIN;
    logic       oRUNNING;
    logic       oTICK;
    logic       oWRAP;
    logic [1:0] oSTATE;

    quarter_sec_stopwatch #(
        .TICKS_PER_SEC(4),
        .MAX_MIN      (9)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSIG_4Hz   (iSIG_4Hz),
        .iSTART_STOP(iSTART_STOP),
        .iCLEAR     (iCLEAR),
        .oSUBSEC    (oSUBSEC),
        .oSEC_ONES  (oSEC_ONES),
        .oSEC_TENS  (oSEC_TENS),
        .oMIN       (oMIN),
        .oRUNNING   (oRUNNING),
        .oTICK      (oTICK),
        .oWRAP      (oWRAP),
        .oSTATE     (oSTATE)
    );

    // ---------------- clock ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int tick_cnt;
    int wrap_cnt;
    int dbl_cnt;
    logic prev_tick;
    logic prev_wrap;

    typedef struct {
        logic sig;
        logic ss;
        logic clr;
        int   sub;
        int   ones;
        int   tens;
        int   mins;
        logic run;
        logic tick;
        logic wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic sig, input logic ss, input logic clr,
                           input int sub, input int ones, input int tens,
                           input int mins, input logic run, input logic tick,
                           input logic wrap);
        vec_t v;
        v.sig = sig; v.ss = ss; v.clr = clr;
        v.sub = sub; v.ones = ones; v.tens = tens; v.mins = mins;
        v.run = run; v.tick = tick; v.wrap = wrap;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input int m, input int t,
                            input int o, input int s);
        chk({name, ".min"},  int'(oMIN),      m);
        chk({name, ".tens"}, int'(oSEC_TENS), t);
        chk({name, ".ones"}, int'(oSEC_ONES), o);
        chk({name, ".sub"},  int'(oSUBSEC),   s);
    endtask

    // Apply inputs for one clock, then leave the strobes low. Outputs are
    // read 1 time unit after the rising edge.
    task automatic cyc(input logic sig, input logic ss, input logic clr);
        iSIG_4Hz    = sig;
        iSTART_STOP = ss;
        iCLEAR      = clr;
        @(posedge iCLK);
        #1;
        iSTART_STOP = 1'b0;
        iCLEAR      = 1'b0;
    endtask

    // Accumulate pulse counts and any back-to-back pulses.
    task automatic obs();
        if (oTICK) tick_cnt++;
        if (oWRAP) wrap_cnt++;
        if ((oTICK && prev_tick) || (oWRAP && prev_wrap)) dbl_cnt++;
        prev_tick = oTICK;
        prev_wrap = oWRAP;
    endtask

    task automatic clr_obs();
        tick_cnt  = 0;
        wrap_cnt  = 0;
        dbl_cnt   = 0;
        prev_tick = 1'b0;
        prev_wrap = 1'b0;
    endtask

    // One wave period: 4 cycles high then 4 low; optional START_STOP strobe
    // on the rising-edge cycle.
    task automatic run_period(input logic ss_rise);
        cyc(1'b1, ss_rise, 1'b0);
        obs();
        repeat (3) begin
            cyc(1'b1, 1'b0, 1'b0);
            obs();
        end
        repeat (4) begin
            cyc(1'b0, 1'b0, 1'b0);
            obs();
        end
    endtask

    task automatic run_periods(input int n);
        for (int i = 0; i < n; i++) run_period(1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Per-cycle vectors:  sig ss clr | sub ones tens min run tick wrap
        add_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // high at release: no tick
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 0, 0, 0, 0, 1, 0, 0); // IDLE -> RUN
        add_vec(1, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        add_vec(1, 0, 0, 1, 0, 0, 0, 1, 0, 0); // held high: no new tick
        add_vec(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 2, 0, 0, 0, 1, 1, 0);
        add_vec(0, 0, 0, 2, 0, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 3, 0, 0, 0, 1, 1, 0);
        add_vec(0, 0, 0, 3, 0, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 0, 1, 0, 0, 1, 1, 0); // carry into seconds
        add_vec(1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        add_vec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0); // RUN -> PAUSE
        add_vec(1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // tick ignored in PAUSE
        add_vec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 1, 0, 0, 1, 0, 0); // PAUSE+tick: not counted, RUN
        add_vec(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        add_vec(1, 1, 0, 1, 1, 0, 0, 0, 1, 0); // RUN+tick: counted, PAUSE
        add_vec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add_vec(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); // clear wins over all
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 0, 0, 0, 1, 0, 0); // IDLE+tick: not counted, RUN
        add_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        add_vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // clear while running

        // Reset with the wave held high.
        iRST        = 1'b1;
        iSIG_4Hz    = 1'b1;
        iSTART_STOP = 1'b0;
        iCLEAR      = 1'b0;
        clr_obs();
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        chk_time("reset", 0, 0, 0, 0);
        chk("reset.running", int'(oRUNNING), 0);
        chk("reset.tick",    int'(oTICK),    0);
        chk("reset.wrap",    int'(oWRAP),    0);
        chk("reset.state",   int'(oSTATE),   0);

        // Table-driven per-cycle vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].sig, vecs[i].ss, vecs[i].clr);
            chk($sformatf("vec%0d.sub",  i), int'(oSUBSEC),   vecs[i].sub);
            chk($sformatf("vec%0d.ones", i), int'(oSEC_ONES), vecs[i].ones);
            chk($sformatf("vec%0d.tens", i), int'(oSEC_TENS), vecs[i].tens);
            chk($sformatf("vec%0d.min",  i), int'(oMIN),      vecs[i].mins);
            chk($sformatf("vec%0d.run",  i), int'(oRUNNING),  int'(vecs[i].run));
            chk($sformatf("vec%0d.tick", i), int'(oTICK),     int'(vecs[i].tick));
            chk($sformatf("vec%0d.wrap", i), int'(oWRAP),     int'(vecs[i].wrap));
        end

        // Four edges after start: 1,2,3,0 and one second.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        clr_obs();
        run_period(1'b0); chk("four.sub1", int'(oSUBSEC), 1);
        run_period(1'b0); chk("four.sub2", int'(oSUBSEC), 2);
        run_period(1'b0); chk("four.sub3", int'(oSUBSEC), 3);
        run_period(1'b0);
        chk_time("four.end", 0, 0, 1, 0);
        chk("four.ticks", tick_cnt, 4);
        chk("four.double", dbl_cnt, 0);

        // 239 ticks to 0:59.3, one more to 1:00.0.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        clr_obs();
        run_periods(239);
        chk_time("pre_min.before", 0, 5, 9, 3);
        run_period(1'b0);
        chk_time("pre_min.after", 1, 0, 0, 0);
        chk("pre_min.wrap", wrap_cnt, 0);

        // Continue to 9:59.3 (2399 ticks total), then wrap.
        run_periods(2399 - 240);
        chk_time("wrap.before", 9, 5, 9, 3);
        chk("wrap.none_yet", wrap_cnt, 0);
        clr_obs();
        run_period(1'b0);
        chk_time("wrap.after", 0, 0, 0, 0);
        chk("wrap.pulses", wrap_cnt, 1);
        chk("wrap.double", dbl_cnt, 0);
        run_period(1'b0);
        chk_time("wrap.continue", 0, 0, 0, 1);
        chk("wrap.running", int'(oRUNNING), 1);

        // Pause at 0:02.1, ten edges ignored, resume to 0:02.2.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        run_periods(9);
        chk_time("pause.at", 0, 0, 2, 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("pause.running", int'(oRUNNING), 0);
        chk("pause.state",   int'(oSTATE),   2);
        clr_obs();
        run_periods(10);
        chk_time("pause.hold", 0, 0, 2, 1);
        chk("pause.ticks", tick_cnt, 0);
        cyc(1'b0, 1'b1, 1'b0);
        run_period(1'b0);
        chk_time("pause.resume", 0, 0, 2, 2);

        // Clear coincident with tick and START_STOP at 0:05.2.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        run_periods(22);
        chk_time("clr.before", 0, 0, 5, 2);
        cyc(1'b1, 1'b1, 1'b1);
        chk_time("clr.after", 0, 0, 0, 0);
        chk("clr.tick",    int'(oTICK),    0);
        chk("clr.running", int'(oRUNNING), 0);
        chk("clr.state",   int'(oSTATE),   0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        chk_time("clr.idle_hold", 0, 0, 0, 0);

        // START_STOP on an edge while running: tick counted, then PAUSE.
        cyc(1'b0, 1'b1, 1'b0);
        clr_obs();
        run_period(1'b1);
        chk_time("ss_edge", 0, 0, 0, 1);
        chk("ss_edge.ticks",   tick_cnt,        1);
        chk("ss_edge.running", int'(oRUNNING), 0);
        chk("ss_edge.state",   int'(oSTATE),   2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
